// File: rtl/adc_acq_pkg.sv
// Shared types and helpers for the ADC acquisition sequencer.
// Contents:
//   state_t        - sequencer FSM states
//   NUM_CHANNELS   - samples per combined frame (two ADCs x eight channels)
//   CHAN_W         - width of the channel index
//   frame_slice()  - picks one 16-bit channel sample out of the two reader frames
package adc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_STREAM,
        ST_ARMED,
        ST_HOLD
    } state_t;

    localparam int NUM_CHANNELS = 16;
    localparam int CHAN_W       = 4;

    // Channel 0 is the most significant 16 bits of ADC1's frame. Channels 8..15
    // continue the same MSB-first order in ADC2's frame. Concatenating
    // {d1, d2} turns both cases into a single slice.
    function automatic logic [15:0] frame_slice(input logic [127:0] d1,
                                                input logic [127:0] d2,
                                                input logic [CHAN_W-1:0] chan);
        logic [255:0] both;
        int           idx;
        both = {d1, d2};
        idx  = 255 - 16 * int'(chan);
        return both[idx -: 16];
    endfunction

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// Sample stream bundle produced by the acquisition sequencer.
// Signals:
//   sample - channel sample data
//   chan   - channel index 0..15
//   last   - high together with channel 15
//   valid  - sample available (producer)
//   ready  - consumer accepts (consumer)
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. Once valid rises, sample/chan/last and valid hold until that transfer.
interface adc_acq_sequencer_if #(parameter int SAMPLE_WIDTH = 16);
    import adc_acq_pkg::*;

    logic [SAMPLE_WIDTH-1:0] sample;
    logic [CHAN_W-1:0]       chan;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (output sample, chan, last, valid, input ready);
    modport slave  (input sample, chan, last, valid, output ready);
endinterface

// File: rtl/adc_period_timer.sv
// Free-running period tick generator.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clear    - forces the count to 0 (has priority over enable)
//   enable   - counter advances only while high
//   period   - tick spacing in clocks; 0 disables ticks
//   tick     - high in the cycle the count equals period-1
module adc_period_timer #(
    parameter int PERIOD_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    tick
);
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] last_cnt;

    assign last_cnt = period - PERIOD_WIDTH'(1);
    assign tick     = enable && (period != '0) && (cnt_q == last_cnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // ">=" rather than "==" so a live shrink of the period below the
            // current count wraps instead of running all the way around.
            if (period == '0 || cnt_q >= last_cnt) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PERIOD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/adc_acq_sequencer.sv
// Acquisition scheduler above the dual-ADC SPI reader.
// Issues periodic / free-running / burst conversion starts, waits for the
// reader's done pulse, latches both 128-bit frames and streams the 16 channel
// samples over valid/ready. Flags overruns and reader timeouts.
// Ports:
//   i_Clk, i_Reset            - clock, synchronous active-high reset
//   i_Enable                  - run request (level)
//   i_Period, i_Burst_Count   - start spacing (0 = free-running), frames per run (0 = continuous)
//   i_Clear_Status            - clears sticky o_Overrun / o_Timeout
//   o_START, o_SPI_Reset      - one-cycle pulses to the reader
//   i_Done, i_Data1, i_Data2  - reader completion and frames
//   o_Sample* / i_Sample_Ready- sample stream (valid/ready)
//   o_Busy, o_Burst_Done      - status
//   o_Overrun, o_Timeout      - sticky error flags
//   o_Frame_Count             - frames fully streamed since reset
//   o_Dbg_State               - current FSM state
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int CHANNELS_PER_ADC = 8,
    parameter int PERIOD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES   = 8192
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Reset,
    input  logic                                 i_Enable,
    input  logic [PERIOD_WIDTH-1:0]              i_Period,
    input  logic [15:0]                          i_Burst_Count,
    input  logic                                 i_Clear_Status,
    output logic                                 o_START,
    output logic                                 o_SPI_Reset,
    input  logic                                 i_Done,
    input  logic [SAMPLE_WIDTH*CHANNELS_PER_ADC-1:0] i_Data1,
    input  logic [SAMPLE_WIDTH*CHANNELS_PER_ADC-1:0] i_Data2,
    output logic [SAMPLE_WIDTH-1:0]              o_Sample,
    output logic [CHAN_W-1:0]                    o_Sample_Chan,
    output logic                                 o_Sample_Last,
    output logic                                 o_Sample_Valid,
    input  logic                                 i_Sample_Ready,
    output logic                                 o_Busy,
    output logic                                 o_Burst_Done,
    output logic                                 o_Overrun,
    output logic                                 o_Timeout,
    output logic [15:0]                          o_Frame_Count,
    output state_t                               o_Dbg_State
);
    localparam int FRAME_BITS = SAMPLE_WIDTH * CHANNELS_PER_ADC;
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   data1_q, data1_d;
    logic [FRAME_BITS-1:0]   data2_q, data2_d;
    logic [CHAN_W-1:0]       chan_q, chan_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [15:0]             burst_cnt_q, burst_cnt_d;
    logic                    start_q, start_d;
    logic                    spi_rst_q, spi_rst_d;
    logic                    burst_done_q, burst_done_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;

    logic                    tick;
    logic                    start_now;
    logic                    overrun_set;
    logic                    timeout_set;
    logic                    timer_run;
    logic                    valid;

    // Timer runs except when idle or parked after a burst; held at 0 in IDLE
    // so the first START of a run lines up with count 0.
    assign timer_run = (state_q != ST_IDLE) && (state_q != ST_HOLD);

    adc_period_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
        .clk    (i_Clk),
        .rst    (i_Reset),
        .clear  (state_q == ST_IDLE),
        .enable (timer_run),
        .period (i_Period),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        chan_d       = chan_q;
        to_cnt_d     = '0;
        frame_cnt_d  = frame_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        start_d      = 1'b0;
        spi_rst_d    = 1'b0;
        burst_done_d = 1'b0;
        start_now    = 1'b0;
        timeout_set  = 1'b0;
        // A tick while a frame is in flight is lost, not queued.
        overrun_set  = tick && (state_q == ST_WAIT_DONE || state_q == ST_STREAM);

        case (state_q)
            ST_IDLE: begin
                if (i_Enable) begin
                    start_d     = 1'b1;
                    burst_cnt_d = '0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (i_Done) begin
                    data1_d = i_Data1;
                    data2_d = i_Data2;
                    chan_d  = '0;
                    state_d = ST_STREAM;
                end else if (to_cnt_q == TO_MAX) begin
                    timeout_set = 1'b1;
                    spi_rst_d   = 1'b1;
                    state_d     = ST_ARMED;
                end
            end
            ST_STREAM: begin
                if (i_Sample_Ready) begin
                    if (chan_q == CHAN_W'(NUM_CHANNELS - 1)) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        state_d     = ST_ARMED;
                    end else begin
                        chan_d = chan_q + CHAN_W'(1);
                    end
                end
            end
            ST_ARMED: begin
                if (!i_Enable) begin
                    state_d = ST_IDLE;
                end else if (i_Burst_Count != 16'd0 && burst_cnt_q == i_Burst_Count) begin
                    burst_done_d = 1'b1;
                    burst_cnt_d  = '0;
                    state_d      = ST_HOLD;
                end else if (i_Period == '0) begin
                    // Free-running: START goes out in this very cycle, i.e. the
                    // cycle right after the last sample transferred.
                    start_now = 1'b1;
                    state_d   = ST_WAIT_DONE;
                end else if (tick) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_HOLD: begin
                if (!i_Enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Set has priority over clear.
        overrun_d = (overrun_q & ~i_Clear_Status) | overrun_set;
        timeout_d = (timeout_q & ~i_Clear_Status) | timeout_set;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            data1_q      <= '0;
            data2_q      <= '0;
            chan_q       <= '0;
            to_cnt_q     <= '0;
            frame_cnt_q  <= '0;
            burst_cnt_q  <= '0;
            start_q      <= 1'b0;
            spi_rst_q    <= 1'b0;
            burst_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            chan_q       <= chan_d;
            to_cnt_q     <= to_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            start_q      <= start_d;
            spi_rst_q    <= spi_rst_d;
            burst_done_q <= burst_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign valid          = (state_q == ST_STREAM);
    assign o_Sample_Valid = valid;
    assign o_Sample       = valid ? SAMPLE_WIDTH'(frame_slice(data1_q, data2_q, chan_q)) : '0;
    assign o_Sample_Chan  = valid ? chan_q : '0;
    assign o_Sample_Last  = valid && (chan_q == CHAN_W'(NUM_CHANNELS - 1));
    assign o_START        = start_q | start_now;
    assign o_SPI_Reset    = spi_rst_q;
    assign o_Burst_Done   = burst_done_q;
    assign o_Overrun      = overrun_q;
    assign o_Timeout      = timeout_q;
    assign o_Frame_Count  = frame_cnt_q;
    assign o_Busy         = (state_q != ST_IDLE);
    assign o_Dbg_State    = state_q;
endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed testbench for adc_acq_sequencer: periodic burst, sample ordering,
// random backpressure, overrun, reader timeout, free-running restart and
// mid-stream reset.
module tb_adc_acq_sequencer;
    import adc_acq_pkg::*;

    logic         i_Clk;
    logic         i_Reset;
    logic         i_Enable;
    logic [31:0]  i_Period;
    logic [15:0]  i_Burst_Count;
    logic         i_Clear_Status;
    logic         o_START;
    logic         o_SPI_Reset;
    logic         i_Done;
    logic [127:0] i_Data1;
    logic [127:0] i_Data2;
    logic         o_Busy;
    logic         o_Burst_Done;
    logic         o_Overrun;
    logic         o_Timeout;
    logic [15:0]  o_Frame_Count;
    state_t       o_Dbg_State;

    adc_acq_sequencer_if #(.SAMPLE_WIDTH(16)) sif ();

    adc_acq_sequencer dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Enable       (i_Enable),
        .i_Period       (i_Period),
        .i_Burst_Count  (i_Burst_Count),
        .i_Clear_Status (i_Clear_Status),
        .o_START        (o_START),
        .o_SPI_Reset    (o_SPI_Reset),
        .i_Done         (i_Done),
        .i_Data1        (i_Data1),
        .i_Data2        (i_Data2),
        .o_Sample       (sif.sample),
        .o_Sample_Chan  (sif.chan),
        .o_Sample_Last  (sif.last),
        .o_Sample_Valid (sif.valid),
        .i_Sample_Ready (sif.ready),
        .o_Busy         (o_Busy),
        .o_Burst_Done   (o_Burst_Done),
        .o_Overrun      (o_Overrun),
        .o_Timeout      (o_Timeout),
        .o_Frame_Count  (o_Frame_Count),
        .o_Dbg_State    (o_Dbg_State)
    );

    // ---------------- clock / reset ----------------
    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    logic [15:0] got_s[$];
    logic [3:0]  got_c[$];
    logic        got_l[$];
    int          got_cyc[$];
    int          start_cyc[$];
    int          spi_n = 0;
    int          spi_cyc = 0;
    int          bd_n = 0;
    int          done_delay = 0;

    logic        hold_pend = 1'b0;
    logic [3:0]  held_c;
    logic [15:0] held_s;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance n clock edges and land 2 time units after the last one, where
    // inputs are driven.
    task automatic adv(input int n);
        repeat (n) @(posedge i_Clk);
        #2;
    endtask

    task automatic clear_logs();
        got_s.delete();
        got_c.delete();
        got_l.delete();
        got_cyc.delete();
        start_cyc.delete();
    endtask

    // Reader model: raises i_Done for one cycle done_delay cycles after START.
    always begin
        @(negedge i_Clk);
        if (o_START === 1'b1 && done_delay != 0) begin
            repeat (done_delay) @(posedge i_Clk);
            #2 i_Done = 1'b1;
            @(posedge i_Clk);
            #2 i_Done = 1'b0;
        end
    end

    // Monitor sampling on the falling edge, away from the active edge.
    always @(negedge i_Clk) begin
        if (o_START === 1'b1) start_cyc.push_back(cyc);
        if (o_SPI_Reset === 1'b1) begin
            spi_n++;
            spi_cyc = cyc;
        end
        if (o_Burst_Done === 1'b1) bd_n++;
        if (hold_pend) begin
            check("hold_stable", {sif.valid, sif.chan, sif.sample}, {1'b1, held_c, held_s});
        end
        hold_pend = (sif.valid === 1'b1) && (sif.ready === 1'b0);
        held_c    = sif.chan;
        held_s    = sif.sample;
        if (sif.valid === 1'b1 && sif.ready === 1'b1) begin
            got_s.push_back(sif.sample);
            got_c.push_back(sif.chan);
            got_l.push_back(sif.last);
            got_cyc.push_back(cyc);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bd0;
        int t0;

        i_Reset        = 1'b1;
        i_Enable       = 1'b0;
        i_Period       = 32'd0;
        i_Burst_Count  = 16'd0;
        i_Clear_Status = 1'b0;
        i_Done         = 1'b0;
        sif.ready      = 1'b1;
        i_Data1        = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        i_Data2        = 128'h0009_000a_000b_000c_000d_000e_000f_0010;

        // ---- reset state ----
        adv(3);
        i_Reset = 1'b0;
        @(negedge i_Clk);
        check("rst_busy",   o_Busy, 0);
        check("rst_valid",  sif.valid, 0);
        check("rst_start",  o_START, 0);
        check("rst_frames", o_Frame_Count, 0);
        check("rst_flags",  {o_Overrun, o_Timeout, o_SPI_Reset, o_Burst_Done}, 0);
        check("rst_state",  o_Dbg_State, ST_IDLE);

        // ---- periodic burst of 3, period 1000, reader 300 clocks ----
        clear_logs();
        i_Period      = 32'd1000;
        i_Burst_Count = 16'd3;
        done_delay    = 300;
        bd0           = bd_n;
        adv(1);
        i_Enable = 1'b1;
        for (int i = 0; i < 3000 && bd_n == bd0; i++) @(negedge i_Clk);
        check("burst_done_seen", bd_n, bd0 + 1);
        check("burst_starts", start_cyc.size(), 3);
        if (start_cyc.size() == 3) begin
            check("burst_space1", start_cyc[1] - start_cyc[0], 1000);
            check("burst_space2", start_cyc[2] - start_cyc[1], 1000);
        end
        check("burst_samples", got_s.size(), 48);
        for (int k = 0; k < 48 && k < got_s.size(); k++) begin
            check("seq_chan",   got_c[k], k % 16);
            check("seq_sample", got_s[k], (k % 16) + 1);
            check("seq_last",   got_l[k], (k % 16) == 15);
        end
        check("burst_frames",  o_Frame_Count, 3);
        check("burst_overrun", o_Overrun, 0);
        adv(20);
        @(negedge i_Clk);
        check("hold_busy",    o_Busy, 1);
        check("hold_state",   o_Dbg_State, ST_HOLD);
        check("hold_nostart", start_cyc.size(), 3);
        check("hold_bd_once", bd_n, bd0 + 1);
        adv(1);
        i_Enable = 1'b0;
        adv(2);
        @(negedge i_Clk);
        check("idle_busy", o_Busy, 0);

        // ---- random backpressure, one frame ----
        clear_logs();
        i_Burst_Count = 16'd1;
        done_delay    = 20;
        bd0           = bd_n;
        i_Enable      = 1'b1;
        for (int i = 0; i < 2000 && bd_n == bd0; i++) begin
            adv(1);
            sif.ready = 1'($urandom_range(0, 1));
        end
        sif.ready = 1'b1;
        check("bp_done_seen", bd_n, bd0 + 1);
        check("bp_samples", got_s.size(), 16);
        for (int k = 0; k < 16 && k < got_s.size(); k++) begin
            check("bp_chan",   got_c[k], k);
            check("bp_sample", got_s[k], k + 1);
            check("bp_last",   got_l[k], k == 15);
        end
        @(negedge i_Clk);
        check("bp_frames",  o_Frame_Count, 4);
        check("bp_overrun", o_Overrun, 0);
        adv(1);
        i_Enable = 1'b0;
        adv(3);

        // ---- overrun: period 200, reader 350 clocks, burst of 2 ----
        clear_logs();
        i_Period      = 32'd200;
        i_Burst_Count = 16'd2;
        done_delay    = 350;
        bd0           = bd_n;
        i_Enable      = 1'b1;
        for (int i = 0; i < 2000 && bd_n == bd0; i++) @(negedge i_Clk);
        check("ovr_done_seen", bd_n, bd0 + 1);
        check("ovr_flag", o_Overrun, 1);
        check("ovr_starts", start_cyc.size(), 2);
        // Ticks at +199 (dropped, in WAIT_DONE) and +399 (in ARMED) -> +400.
        if (start_cyc.size() == 2) check("ovr_space", start_cyc[1] - start_cyc[0], 400);
        check("ovr_frames", o_Frame_Count, 6);
        adv(1);
        i_Clear_Status = 1'b1;
        adv(1);
        i_Clear_Status = 1'b0;
        @(negedge i_Clk);
        check("ovr_cleared", o_Overrun, 0);
        i_Enable = 1'b0;
        adv(3);

        // ---- reader timeout ----
        clear_logs();
        i_Period      = 32'd20000;
        i_Burst_Count = 16'd1;
        done_delay    = 0;
        spi_n         = 0;
        i_Enable      = 1'b1;
        for (int i = 0; i < 9000 && spi_n == 0; i++) @(negedge i_Clk);
        check("to_spi_seen", spi_n, 1);
        if (start_cyc.size() > 0) check("to_latency", spi_cyc - start_cyc[0], 8192);
        adv(3);
        @(negedge i_Clk);
        check("to_spi_once", spi_n, 1);
        check("to_flag",     o_Timeout, 1);
        check("to_nosample", got_s.size(), 0);
        check("to_frames",   o_Frame_Count, 6);
        check("to_starts",   start_cyc.size(), 1);
        adv(1);
        i_Enable       = 1'b0;
        i_Clear_Status = 1'b1;
        adv(1);
        i_Clear_Status = 1'b0;
        @(negedge i_Clk);
        check("to_cleared", o_Timeout, 0);
        adv(3);

        // ---- free-running continuous, then reset mid-stream ----
        clear_logs();
        i_Period      = 32'd0;
        i_Burst_Count = 16'd0;
        done_delay    = 5;
        i_Enable      = 1'b1;
        for (int i = 0; i < 200 && start_cyc.size() < 2; i++) @(negedge i_Clk);
        check("fr_starts", start_cyc.size() >= 2, 1);
        check("fr_first_frame", got_s.size(), 16);
        if (start_cyc.size() >= 2 && got_cyc.size() >= 16) begin
            check("fr_restart", start_cyc[1], got_cyc[15] + 1);
            check("fr_space", start_cyc[1] - start_cyc[0], 22);
        end
        t0 = 0;
        while (t0 < 100 && sif.valid !== 1'b1) begin
            @(negedge i_Clk);
            t0++;
        end
        check("fr_second_stream", sif.valid, 1);
        adv(1);
        i_Reset  = 1'b1;
        i_Enable = 1'b0;
        @(negedge i_Clk);
        @(negedge i_Clk);
        check("mr_valid",  sif.valid, 0);
        check("mr_data",   {sif.sample, sif.chan, sif.last}, 0);
        check("mr_busy",   o_Busy, 0);
        check("mr_start",  o_START, 0);
        check("mr_frames", o_Frame_Count, 0);
        check("mr_flags",  {o_Overrun, o_Timeout, o_SPI_Reset, o_Burst_Done}, 0);
        check("mr_state",  o_Dbg_State, ST_IDLE);
        adv(1);
        i_Reset = 1'b0;
        adv(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
Acquisition scheduler sitting above the dual-ADC SPI reader. Issues periodic or burst conversion starts, waits for the reader's done pulse, and latches both 128-bit frames. Streams the 16 channel samples out over a valid/ready interface. Flags overruns and reader timeouts, and resets a hung reader.

Parameters:
SAMPLE_WIDTH, 16, bits per channel sample
CHANNELS_PER_ADC, 8, samples packed per 128-bit reader word
PERIOD_WIDTH, 32, width of sample-period register
TIMEOUT_CYCLES, 8192, max clocks from START to reader done before abort

Ports:
i_Clk  input  1  system clock
i_Reset  input  1  synchronous active-high reset
i_Enable  input  1  run request; level-sensitive
i_Period  input  PERIOD_WIDTH  clocks between START pulses; 0 = free-running
i_Burst_Count  input  16  frames per run; 0 = continuous
i_Clear_Status  input  1  one-cycle pulse; clears sticky flags
o_START  output  1  one-cycle conversion request to reader
o_SPI_Reset  output  1  one-cycle reset pulse to reader on timeout
i_Done  input  1  reader frame-complete pulse
i_Data1  input  128  ADC1 frame, stable from i_Done onward
i_Data2  input  128  ADC2 frame, stable from i_Done onward
o_Sample  output  SAMPLE_WIDTH  sample data
o_Sample_Chan  output  4  channel index 0..15
o_Sample_Last  output  1  high with channel 15
o_Sample_Valid  output  1  sample available
i_Sample_Ready  input  1  downstream accepts
o_Busy  output  1  high in any state but IDLE
o_Burst_Done  output  1  one-cycle pulse when the burst count is reached
o_Overrun  output  1  sticky: period tick while frame in flight
o_Timeout  output  1  sticky: reader failed to finish
o_Frame_Count  output  16  frames fully streamed since reset; wraps

Behaviour:
- Reset: all outputs are 0; state IDLE; period counter, frame counter, burst counter and channel index are 0.
- State IDLE: on i_Enable=1, pulse o_START on the next cycle, clear the period counter, go to WAIT_DONE.
- State WAIT_DONE:
  - Timeout counter increments each cycle.
  - On i_Done=1: latch i_Data1 and i_Data2, set channel index to 0, go to STREAM.
  - If the counter reaches TIMEOUT_CYCLES-1 with no i_Done: set o_Timeout, pulse o_SPI_Reset, discard the frame, go to ARMED. The frame count is not incremented.
- State STREAM:
  - o_Sample_Valid=1.
  - Channel c<8 is i_Data1 bits [127-16c -: 16]; channel c>=8 is i_Data2 bits [127-16(c-8) -: 16].
  - Transfer occurs on valid & ready. Valid, data and channel hold stable until the transfer.
  - After channel 15 transfers: increment the frame count and burst counter, drop valid, go to ARMED. Valid drops in the same cycle.
- State ARMED:
  - If i_Enable=0, go to IDLE.
  - Else if the burst limit is reached (i_Burst_Count!=0 and burst counter==i_Burst_Count): pulse o_Burst_Done, clear the burst counter, go to HOLD.
  - Else in free-running mode: pulse o_START immediately.
  - Else wait for the next period tick, then pulse o_START and go to WAIT_DONE.
- State HOLD: wait for i_Enable=0, then go to IDLE. A burst does not retrigger while enable stays high.
- Period counter:
  - Runs whenever state is not IDLE or HOLD. Counts 0..i_Period-1; the tick occurs at i_Period-1, then the counter wraps to 0.
  - START pulses are spaced exactly i_Period clocks when downstream keeps up.
  - A tick in WAIT_DONE or STREAM sets o_Overrun and is dropped, not queued.
  - i_Period=1 with no free-running mode is treated as 1.
- i_Enable falling mid-frame: the current frame completes WAIT_DONE and STREAM, then ARMED goes to IDLE. No partial frame is emitted.
- i_Clear_Status clears o_Overrun and o_Timeout. If it coincides with a new set event, the set wins.
- i_Period and i_Burst_Count are sampled live. Changing them mid-run takes effect at the next comparison.
- Reset asserted mid-operation returns the block to IDLE in one cycle. Valid drops immediately.

Decomposition:
- Package adc_acq_pkg holds:
  - The state enum (IDLE, WAIT_DONE, STREAM, ARMED, HOLD).
  - Localparams for channel count (16) and channel index width (4).
  - The frame bit-slice helper function.
- Sub-module adc_period_timer: free-running tick generator with clear, enable and period inputs, and a tick output.

Test Plan:
- i_Period=1000, i_Burst_Count=3, ready tied high, reader done 300 clocks after START -> 3 START pulses spaced 1000 clocks; 48 samples; o_Burst_Done once; o_Frame_Count=3; o_Busy stays high until enable drops.
- i_Data1=0x0001_0002…0008 and i_Data2=0x0009…0010 -> o_Sample sequence 1..16 with o_Sample_Chan 0..15; o_Sample_Last only on channel 15.
- Ready toggled randomly during STREAM -> no sample lost or duplicated; data stable while valid=1 and ready=0.
- i_Period=200, reader done 350 clocks after START -> o_Overrun set; next START only after stream completes; i_Clear_Status clears the flag.
- i_Done never asserted -> after TIMEOUT_CYCLES o_Timeout=1 and one o_SPI_Reset pulse; no samples emitted; o_Frame_Count unchanged.
- i_Period=0 with continuous bursts -> the next o_START is issued the cycle after the last sample transfers; i_Reset asserted mid-STREAM leaves all outputs at 0 the following cycle.
